// File: rtl/pht_access_scheduler.sv
// Pattern history table port scheduler.
// One single-ported table of 2-bit saturating counters is shared between
// fetch-stage lookups and execute-stage counter updates. Updates are queued
// in a small FIFO and applied as read-modify-write sequences. After reset the
// whole table is swept to weakly-not-taken before either side is served.
module pht_access_scheduler #(
    parameter int IDX_W     = 6,
    parameter int UPD_DEPTH = 4,
    parameter int PC_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_req,
    input  logic [PC_W-1:0]              fetch_pc,
    output logic                         fetch_ready,
    output logic                         fetch_valid,
    output logic                         fetch_taken,
    input  logic                         upd_valid,
    input  logic [PC_W-1:0]              upd_pc,
    input  logic                         upd_taken,
    output logic                         upd_ready,
    output logic                         pht_en,
    output logic                         pht_we,
    output logic [IDX_W-1:0]             pht_addr,
    output logic [1:0]                   pht_wdata,
    input  logic [1:0]                   pht_rdata,
    output logic                         busy,
    output logic [$clog2(UPD_DEPTH):0]   upd_count
);

    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_UPD_RD = 2'd2;
    localparam logic [1:0] ST_UPD_WR = 2'd3;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(UPD_DEPTH);
    localparam logic [CNT_W-1:0] EMPTY_CNT = {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] LAST_IDX  = {IDX_W{1'b1}};

    // Next value of a 2-bit saturating counter given the resolved outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            3'b1_00: nxt = 2'b01;
            3'b1_01: nxt = 2'b11;
            3'b1_10: nxt = 2'b11;
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            3'b0_01: nxt = 2'b00;
            3'b0_10: nxt = 2'b01;
            3'b0_11: nxt = 2'b10;
            default: nxt = 2'b01;
        endcase
        return nxt;
    endfunction

    // Registered state
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       new_q, new_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic [IDX_W-1:0] fifo_idx_q [UPD_DEPTH];
    logic [IDX_W-1:0] fifo_idx_d [UPD_DEPTH];
    logic             fifo_tkn_q [UPD_DEPTH];
    logic             fifo_tkn_d [UPD_DEPTH];

    // Combinational helpers
    logic [IDX_W-1:0] fetch_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             head_tkn_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             en_s;
    logic             we_s;
    logic [IDX_W-1:0] addr_s;
    logic [1:0]       wdata_s;
    logic             fetch_ready_s;
    logic             unused_pc_bits_s;

    assign fetch_idx_s = fetch_pc[IDX_W+1:2];
    assign upd_idx_s   = upd_pc[IDX_W+1:2];
    assign head_idx_s  = fifo_idx_q[head_q];
    assign head_tkn_s  = fifo_tkn_q[head_q];
    assign full_s      = (count_q == FULL_CNT);
    assign empty_s     = (count_q == EMPTY_CNT);
    assign push_s      = upd_valid & ~full_s;

    // PC bits outside the table index do not influence the prediction.
    assign unused_pc_bits_s = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0],
                                upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    // Port control and sequencing: sweep, arbitrate, then read-modify-write.
    always_comb begin
        state_d       = state_q;
        sweep_d       = sweep_q;
        new_d         = new_q;
        fetch_valid_d = 1'b0;
        pop_s         = 1'b0;
        en_s          = 1'b0;
        we_s          = 1'b0;
        addr_s        = sweep_q;
        wdata_s       = 2'b00;
        fetch_ready_s = 1'b0;
        case (state_q)
            ST_INIT: begin
                en_s    = 1'b1;
                we_s    = 1'b1;
                addr_s  = sweep_q;
                wdata_s = 2'b01;
                sweep_d = sweep_q + IDX_W'(1);
                if (sweep_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                if (full_s) begin
                    // A full queue bounds how long fetch may starve updates.
                    en_s    = 1'b1;
                    addr_s  = head_idx_s;
                    state_d = ST_UPD_RD;
                end else if (fetch_req) begin
                    fetch_ready_s = 1'b1;
                    en_s          = 1'b1;
                    addr_s        = fetch_idx_s;
                    fetch_valid_d = 1'b1;
                end else if (!empty_s) begin
                    en_s    = 1'b1;
                    addr_s  = head_idx_s;
                    state_d = ST_UPD_RD;
                end else begin
                    en_s = 1'b0;
                end
            end
            ST_UPD_RD: begin
                // Read data for the head entry arrives now; the port idles.
                new_d   = ctr_next(pht_rdata, head_tkn_s);
                state_d = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                en_s    = 1'b1;
                we_s    = 1'b1;
                addr_s  = head_idx_s;
                wdata_s = new_q;
                pop_s   = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Update FIFO bookkeeping: storage, pointers and occupancy.
    always_comb begin
        fifo_idx_d = fifo_idx_q;
        fifo_tkn_d = fifo_tkn_q;
        tail_d     = tail_q;
        head_d     = head_q;
        if (push_s) begin
            fifo_idx_d[tail_q] = upd_idx_s;
            fifo_tkn_d[tail_q] = upd_taken;
            tail_d             = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // State registers; reset abandons any in-flight read-modify-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_INIT;
            sweep_q       <= {IDX_W{1'b0}};
            head_q        <= {PTR_W{1'b0}};
            tail_q        <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            new_q         <= 2'b00;
            fetch_valid_q <= 1'b0;
            for (int i = 0; i < UPD_DEPTH; i++) begin
                fifo_idx_q[i] <= {IDX_W{1'b0}};
                fifo_tkn_q[i] <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            new_q         <= new_d;
            fetch_valid_q <= fetch_valid_d;
            fifo_idx_q    <= fifo_idx_d;
            fifo_tkn_q    <= fifo_tkn_d;
        end
    end

    // Port strobes are masked while reset is held so no access escapes.
    assign pht_en      = en_s & ~rst;
    assign pht_we      = we_s & ~rst;
    assign pht_addr    = addr_s;
    assign pht_wdata   = wdata_s;
    assign fetch_ready = fetch_ready_s & ~rst;
    assign fetch_valid = fetch_valid_q;
    assign fetch_taken = fetch_valid_q & pht_rdata[1];
    assign upd_ready   = ~full_s;
    assign busy        = (state_q == ST_INIT);
    assign upd_count   = count_q;

endmodule

// File: tb/tb_pht_access_scheduler.sv
// Directed bench for pht_access_scheduler with a behavioural PHT memory and
// a log of every run-time table write.
module tb_pht_access_scheduler;

    localparam int IDX_W     = 6;
    localparam int UPD_DEPTH = 4;
    localparam int PC_W      = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_req = 1'b0;
    logic [PC_W-1:0]   fetch_pc = '0;
    logic              fetch_ready;
    logic              fetch_valid;
    logic              fetch_taken;
    logic              upd_valid = 1'b0;
    logic [PC_W-1:0]   upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic              upd_ready;
    logic              pht_en;
    logic              pht_we;
    logic [IDX_W-1:0]  pht_addr;
    logic [1:0]        pht_wdata;
    logic [1:0]        pht_rdata = 2'b00;
    logic              busy;
    logic [2:0]        upd_count;

    logic [1:0] mem [64];
    logic [7:0] wlog [$];

    int n_cmp = 0;
    int n_err = 0;

    pht_access_scheduler #(.IDX_W(IDX_W), .UPD_DEPTH(UPD_DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_taken(fetch_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .pht_en(pht_en), .pht_we(pht_we), .pht_addr(pht_addr),
        .pht_wdata(pht_wdata), .pht_rdata(pht_rdata),
        .busy(busy), .upd_count(upd_count)
    );

    always #5 clk = ~clk;

    // Synchronous single-port table model.
    always @(posedge clk) begin
        if (pht_en) begin
            if (pht_we) mem[pht_addr] <= pht_wdata;
            else        pht_rdata <= mem[pht_addr];
        end
    end

    // Record run-time writes as {index, value}.
    always @(posedge clk) begin
        if (!rst && pht_en === 1'b1 && pht_we === 1'b1 && busy === 1'b0)
            wlog.push_back({pht_addr, pht_wdata});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_upd(input logic [31:0] pc, input logic tk);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = tk;
        #1;
        check_eq("push_upd_ready", 32'(upd_ready), 32'd1);
        cycle();
        upd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (upd_count == 3'd0) break;
            cycle();
        end
        check_eq({tag, "_drain"}, 32'(upd_count), 32'd0);
    endtask

    task automatic fetch_chk(input logic [31:0] pc, input logic exp_tk, input string tag);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        #1;
        check_eq({tag, "_ready"}, 32'(fetch_ready), 32'd1);
        cycle();
        fetch_req = 1'b0;
        check_eq({tag, "_valid"}, 32'(fetch_valid), 32'd1);
        check_eq({tag, "_taken"}, 32'(fetch_taken), 32'(exp_tk));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state; a pending fetch must not be accepted under reset.
        repeat (3) @(posedge clk);
        #1;
        fetch_req = 1'b1;
        fetch_pc  = 32'h0000_0104;
        #1;
        check_eq("rst_en", 32'(pht_en), 32'd0);
        check_eq("rst_we", 32'(pht_we), 32'd0);
        check_eq("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_count", 32'(upd_count), 32'd0);
        check_eq("rst_fvalid", 32'(fetch_valid), 32'd0);
        check_eq("rst_ftaken", 32'(fetch_taken), 32'd0);
        check_eq("rst_upd_ready", 32'(upd_ready), 32'd1);

        // Init sweep over all 64 entries with fetch held pending.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) begin
            check_eq("init_we", 32'(pht_we), 32'd1);
            check_eq("init_addr", 32'(pht_addr), 32'(i));
            check_eq("init_wdata", 32'(pht_wdata), 32'd1);
            check_eq("init_busy", 32'(busy), 32'd1);
            check_eq("init_fetch_ready", 32'(fetch_ready), 32'd0);
            cycle();
        end
        check_eq("run_busy", 32'(busy), 32'd0);
        check_eq("first_fetch_ready", 32'(fetch_ready), 32'd1);
        check_eq("first_fetch_addr", 32'(pht_addr), 32'd1);
        check_eq("first_fetch_we", 32'(pht_we), 32'd0);
        cycle();
        fetch_req = 1'b0;
        check_eq("first_fetch_valid", 32'(fetch_valid), 32'd1);
        check_eq("first_fetch_taken", 32'(fetch_taken), 32'd0);
        cycle();
        check_eq("fetch_valid_drop", 32'(fetch_valid), 32'd0);

        // Taken x2 then not-taken x2 on index 1.
        wlog.delete();
        push_upd(32'h0000_0104, 1'b1);
        push_upd(32'h0000_0104, 1'b1);
        wait_drain("tk2");
        check_eq("tk2_nwr", 32'(wlog.size()), 32'd2);
        check_eq("tk2_wr0", 32'(wlog[0]), 32'({6'd1, 2'b11}));
        check_eq("tk2_wr1", 32'(wlog[1]), 32'({6'd1, 2'b11}));
        fetch_chk(32'h0000_0104, 1'b1, "tk2_fetch");
        wlog.delete();
        push_upd(32'h0000_0104, 1'b0);
        push_upd(32'h0000_0104, 1'b0);
        wait_drain("nt2");
        check_eq("nt2_nwr", 32'(wlog.size()), 32'd2);
        check_eq("nt2_wr0", 32'(wlog[0]), 32'({6'd1, 2'b10}));
        check_eq("nt2_wr1", 32'(wlog[1]), 32'({6'd1, 2'b01}));
        fetch_chk(32'h0000_0104, 1'b0, "nt2_fetch");

        // Fetch held high while the queue fills; full queue forces an update.
        wlog.delete();
        fetch_req = 1'b1;
        fetch_pc  = 32'h0000_0104;
        for (int k = 0; k < 4; k++) begin
            upd_valid = 1'b1;
            upd_pc    = 32'h0000_0108;
            upd_taken = 1'b1;
            #1;
            check_eq("fill_fetch_ready", 32'(fetch_ready), 32'd1);
            check_eq("fill_count", 32'(upd_count), 32'(k));
            cycle();
        end
        upd_pc    = 32'h0000_010C;
        upd_taken = 1'b0;
        #1;
        check_eq("full_count", 32'(upd_count), 32'd4);
        check_eq("full_upd_ready", 32'(upd_ready), 32'd0);
        check_eq("full_fetch_ready", 32'(fetch_ready), 32'd0);
        check_eq("full_rd_en", 32'(pht_en), 32'd1);
        check_eq("full_rd_we", 32'(pht_we), 32'd0);
        check_eq("full_rd_addr", 32'(pht_addr), 32'd2);
        cycle();
        check_eq("updrd_fetch_ready", 32'(fetch_ready), 32'd0);
        check_eq("updrd_en", 32'(pht_en), 32'd0);
        check_eq("updrd_count", 32'(upd_count), 32'd4);
        check_eq("updrd_upd_ready", 32'(upd_ready), 32'd0);
        cycle();
        check_eq("updwr_fetch_ready", 32'(fetch_ready), 32'd0);
        check_eq("updwr_we", 32'(pht_we), 32'd1);
        check_eq("updwr_addr", 32'(pht_addr), 32'd2);
        check_eq("updwr_wdata", 32'(pht_wdata), 32'd3);
        check_eq("updwr_count", 32'(upd_count), 32'd4);
        check_eq("updwr_upd_ready", 32'(upd_ready), 32'd0);
        cycle();
        check_eq("resume_count", 32'(upd_count), 32'd3);
        check_eq("resume_upd_ready", 32'(upd_ready), 32'd1);
        check_eq("resume_fetch_ready", 32'(fetch_ready), 32'd1);
        cycle();
        upd_valid = 1'b0;
        fetch_req = 1'b0;
        check_eq("refill_count", 32'(upd_count), 32'd4);
        wait_drain("fill");
        check_eq("fill_nwr", 32'(wlog.size()), 32'd5);
        check_eq("fill_wr0", 32'(wlog[0]), 32'({6'd2, 2'b11}));
        check_eq("fill_wr3", 32'(wlog[3]), 32'({6'd2, 2'b11}));
        check_eq("fill_wr4", 32'(wlog[4]), 32'({6'd3, 2'b00}));

        // Push coinciding with the write-back pop keeps occupancy constant.
        wlog.delete();
        upd_valid = 1'b1;
        upd_pc    = 32'h0000_010C;
        upd_taken = 1'b1;
        cycle();
        upd_valid = 1'b0;
        check_eq("pp_count_a1", 32'(upd_count), 32'd1);
        cycle();
        cycle();
        check_eq("pp_is_wr", 32'(pht_we), 32'd1);
        upd_valid = 1'b1;
        #1;
        check_eq("pp_upd_ready", 32'(upd_ready), 32'd1);
        cycle();
        upd_valid = 1'b0;
        check_eq("pp_count_same", 32'(upd_count), 32'd1);
        wait_drain("pp");
        check_eq("pp_nwr", 32'(wlog.size()), 32'd2);
        check_eq("pp_wr0", 32'(wlog[0]), 32'({6'd3, 2'b01}));
        check_eq("pp_wr1", 32'(wlog[1]), 32'({6'd3, 2'b11}));

        // Reset in the middle of a write-back cancels the write.
        push_upd(32'h0000_0114, 1'b1);
        cycle();
        cycle();
        check_eq("mid_rmw_we", 32'(pht_we), 32'd1);
        check_eq("mid_rmw_addr", 32'(pht_addr), 32'd5);
        wlog.delete();
        rst = 1'b1;
        #1;
        check_eq("rstwr_we", 32'(pht_we), 32'd0);
        check_eq("rstwr_en", 32'(pht_en), 32'd0);
        check_eq("rstwr_count", 32'(upd_count), 32'd0);
        check_eq("rstwr_busy", 32'(busy), 32'd1);
        cycle();
        rst = 1'b0;
        #1;
        check_eq("resweep_addr", 32'(pht_addr), 32'd0);
        check_eq("resweep_we", 32'(pht_we), 32'd1);
        check_eq("resweep_busy", 32'(busy), 32'd1);
        repeat (64) cycle();
        check_eq("resweep_done", 32'(busy), 32'd0);
        check_eq("rstwr_nwr", 32'(wlog.size()), 32'd0);

        // No bypass: fetch ahead of a pending update sees the old counter.
        wlog.delete();
        fetch_req = 1'b1;
        fetch_pc  = 32'h0000_0114;
        upd_valid = 1'b1;
        upd_pc    = 32'h0000_0114;
        upd_taken = 1'b1;
        #1;
        check_eq("nb_ready0", 32'(fetch_ready), 32'd1);
        cycle();
        upd_valid = 1'b0;
        #1;
        check_eq("nb_ready1", 32'(fetch_ready), 32'd1);
        check_eq("nb_count", 32'(upd_count), 32'd1);
        check_eq("nb_valid0", 32'(fetch_valid), 32'd1);
        check_eq("nb_taken0", 32'(fetch_taken), 32'd0);
        cycle();
        fetch_req = 1'b0;
        check_eq("nb_valid1", 32'(fetch_valid), 32'd1);
        check_eq("nb_taken1", 32'(fetch_taken), 32'd0);
        wait_drain("nb");
        check_eq("nb_wr0", 32'(wlog[0]), 32'({6'd5, 2'b11}));
        fetch_chk(32'h0000_0114, 1'b1, "nb_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
